// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// Frame: HDR_LO, HDR_HI, 4*N data bytes, XOR checksum byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;
  localparam int LANE_W     = 2;

endpackage

// File: rtl/imem_loader.sv
// Host byte-stream loader for the instruction RAM write port.
// Holds the core in reset while a frame is being loaded.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] TO_LAST =
    IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LANE_W-1:0] LANE_LAST =
    LANE_W'(WORD_BYTES - 1);

  loader_state_t     state, nxt;
  logic [LANE_W-1:0] lane;
  logic [23:0]       wbuf;
  logic [ADDR_W-1:0] wcnt;
  logic [ADDR_W-1:0] last_idx;
  logic [7:0]        hdr_lo;
  logic [7:0]        csum;
  logic [IW-1:0]     idle;

  logic acc;
  logic start_go;
  logic word_end;
  logic last_word;
  logic timeout_hit;

  assign byte_ready = (state == HDR_LO) || (state == HDR_HI) ||
                      (state == DATA)   || (state == CHECK);
  assign core_hold  = byte_ready;
  assign done       = (state == DONE);
  assign error      = (state == ERR);

  assign acc       = byte_valid & byte_ready;
  assign start_go  = start & ~byte_ready & ~(state == IDLE ? 1'b0 : 1'b0);
  assign word_end  = acc && (state == DATA) && (lane == LANE_LAST);
  assign last_word = (wcnt == last_idx);

  // Idle counter reaching TIMEOUT-1 marks the TIMEOUT-th idle cycle.
  assign timeout_hit = (TIMEOUT != 0) && byte_ready &&
                       !acc && (idle == TO_LAST);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) nxt = HDR_LO;
      HDR_LO:          if (acc) nxt = HDR_HI;
      HDR_HI:          if (acc) nxt = DATA;
      DATA:            if (word_end && last_word) nxt = CHECK;
      CHECK: begin
        if (acc) nxt = (byte_data == csum) ? DONE : ERR;
      end
      default:         nxt = IDLE;
    endcase
    if (timeout_hit) nxt = ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lane      <= '0;
      wbuf      <= '0;
      wcnt      <= '0;
      last_idx  <= '0;
      hdr_lo    <= '0;
      csum      <= '0;
      idle      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_go) begin
        lane <= '0;
        wcnt <= '0;
        csum <= '0;
        idle <= '0;
      end else if (byte_ready) begin
        if (acc)                  idle <= '0;
        else if (idle != TO_LAST) idle <= idle + 1'b1;
      end
      if (acc) begin
        unique case (state)
          HDR_LO: hdr_lo <= byte_data;
          HDR_HI: last_idx <= ADDR_W'({byte_data, hdr_lo});
          DATA: begin
            csum <= csum ^ byte_data;
            if (lane == LANE_LAST) begin
              mem_we    <= 1'b1;
              mem_addr  <= wcnt;
              mem_wdata <= {byte_data, wbuf};
              lane      <= '0;
              // Stop at the last index so N = depth never wraps.
              if (!last_word) wcnt <= wcnt + 1'b1;
            end else begin
              wbuf[{lane, 3'b000} +: 8] <= byte_data;
              lane <= lane + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
